turtle_motion_ctrl: RTL and testbench

- Upstream feeder of the multi-turtle sprite renderer.
- Holds position (x, y) and 4-bit control (color_sel[3:2], id_sel[1:0]) for N turtles, written over the MMIO slot bus.
- Once per frame, on a frame tick, a sequencer adds per-turtle signed velocities to the stored positions, one turtle per clock, with modular wrap at the screen edges.
- Drives the renderer's x/y/ctrl inputs as packed registered buses.

---
 rtl/turtle_motion_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_turtle_motion_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turtle_motion_ctrl.sv
// Position/control store for N turtles feeding the sprite renderer, with a
// per-frame motion sequencer that advances one enabled turtle per clock.
module turtle_motion_ctrl #(
  parameter int N     = 20,
  parameter int H_MAX = 640,
  parameter int V_MAX = 480
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cs,
  input  logic            write,
  input  logic [5:0]      addr,
  input  logic [31:0]     wr_data,
  output logic [31:0]     rd_data,
  input  logic            frame_tick,
  output logic [N*11-1:0] x_flat,
  output logic [N*11-1:0] y_flat,
  output logic [N*4-1:0]  ctrl_flat,
  output logic            busy,
  output logic            done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_UPDATE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [5:0]    CSR_ADDR = 6'h3F;
  localparam logic [5:0]    N_ADDR   = 6'(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [12:0]   H_MOD    = 13'(H_MAX);
  localparam logic [12:0]   V_MOD    = 13'(V_MAX);

  logic [1:0]    state_reg;
  logic [IW-1:0] idx_reg;
  logic [15:0]   frame_cnt_reg;
  logic          overrun_reg;
  logic          freeze_reg;
  logic          busy_reg;
  logic          done_reg;

  logic [N*4-1:0] dx_all;
  logic [N*4-1:0] dy_all;
  logic [N-1:0]   en_all;

  logic [4:0] wr_idx;
  logic       idx_ok;
  logic       pos_wr;
  logic       mot_wr;
  logic       csr_wr;

  assign wr_idx = addr[4:0];
  assign idx_ok = ({1'b0, wr_idx} < N_ADDR);
  assign csr_wr = cs && write && (addr == CSR_ADDR);
  assign pos_wr = cs && write && !addr[5] && idx_ok;
  assign mot_wr = cs && write && addr[5] && idx_ok && (addr != CSR_ADDR);

  // One shared motion datapath, steered by the sequencer index.
  logic [10:0] cur_x;
  logic [10:0] cur_y;
  logic [3:0]  cur_dx;
  logic [3:0]  cur_dy;
  logic [10:0] new_x;
  logic [10:0] new_y;
  logic        commit;

  // Sum carried in 13 bits so a software-written position near 2047 plus a
  // positive velocity is not mistaken for a negative result.
  function automatic logic [10:0] wrap_add(input logic [10:0] pos,
                                           input logic [3:0]  vel,
                                           input logic [12:0] modulus);
    logic [12:0] s;
    logic [12:0] r;
    s = {2'b00, pos} + {{9{vel[3]}}, vel};
    if (s[12])
      r = s + modulus;
    else if (s >= modulus)
      r = s - modulus;
    else
      r = s;
    return r[10:0];
  endfunction

  assign cur_x  = x_flat[11*idx_reg +: 11];
  assign cur_y  = y_flat[11*idx_reg +: 11];
  assign cur_dx = dx_all[4*idx_reg +: 4];
  assign cur_dy = dy_all[4*idx_reg +: 4];
  assign new_x  = wrap_add(cur_x, cur_dx, H_MOD);
  assign new_y  = wrap_add(cur_y, cur_dy, V_MOD);
  assign commit = (state_reg == S_UPDATE) && en_all[idx_reg];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_turtle
      logic [10:0] x_reg;
      logic [10:0] y_reg;
      logic [3:0]  ctrl_reg;
      logic [3:0]  dx_reg;
      logic [3:0]  dy_reg;
      logic        en_reg;
      logic        sel_wr;
      logic        sel_upd;

      assign sel_wr  = (wr_idx == 5'(gi));
      assign sel_upd = commit && (idx_reg == IW'(gi));

      always_ff @(posedge clk) begin
        if (reset) begin
          x_reg    <= '0;
          y_reg    <= '0;
          ctrl_reg <= '0;
          dx_reg   <= '0;
          dy_reg   <= '0;
          en_reg   <= 1'b0;
        end else begin
          // A software position write overrides this frame's motion result.
          if (pos_wr && sel_wr) begin
            x_reg <= wr_data[10:0];
            y_reg <= wr_data[21:11];
          end else if (sel_upd) begin
            x_reg <= new_x;
            y_reg <= new_y;
          end
          if (mot_wr && sel_wr) begin
            ctrl_reg <= wr_data[3:0];
            dx_reg   <= wr_data[7:4];
            dy_reg   <= wr_data[11:8];
            en_reg   <= wr_data[12];
          end
        end
      end

      assign x_flat[11*gi +: 11]  = x_reg;
      assign y_flat[11*gi +: 11]  = y_reg;
      assign ctrl_flat[4*gi +: 4] = ctrl_reg;
      assign dx_all[4*gi +: 4]    = dx_reg;
      assign dy_all[4*gi +: 4]    = dy_reg;
      assign en_all[gi]           = en_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      idx_reg       <= '0;
      frame_cnt_reg <= '0;
      overrun_reg   <= 1'b0;
      freeze_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      if (csr_wr) begin
        freeze_reg <= wr_data[0];
        if (wr_data[1])
          overrun_reg <= 1'b0;
      end
      case (state_reg)
        S_IDLE: begin
          done_reg <= 1'b0;
          if (frame_tick && !freeze_reg) begin
            state_reg <= S_UPDATE;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        S_UPDATE: begin
          if (idx_reg == LAST_IDX) begin
            state_reg <= S_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        S_DONE: begin
          state_reg     <= S_IDLE;
          done_reg      <= 1'b0;
          frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
      // Placed after the clear so a tick landing with a clear still sticks.
      if (frame_tick && (state_reg != S_IDLE))
        overrun_reg <= 1'b1;
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;

  always_comb begin
    rd_data = '0;
    if (addr == CSR_ADDR)
      rd_data = {14'b0, frame_cnt_reg, overrun_reg, freeze_reg};
    else if (idx_ok && addr[5])
      rd_data = {19'b0, en_all[wr_idx], dy_all[4*wr_idx +: 4],
                 dx_all[4*wr_idx +: 4], ctrl_flat[4*wr_idx +: 4]};
    else if (idx_ok)
      rd_data = {10'b0, y_flat[11*wr_idx +: 11], x_flat[11*wr_idx +: 11]};
  end

endmodule

// File: tb/tb_turtle_motion_ctrl.sv
// Scoreboard bench for turtle_motion_ctrl: expectations are queued as stimulus
// is driven and popped against DUT observations at the end of each scenario.
module tb_turtle_motion_ctrl;

  localparam int N = 20;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            cs = 1'b0;
  logic            write = 1'b0;
  logic [5:0]      addr = '0;
  logic [31:0]     wr_data = '0;
  logic [31:0]     rd_data;
  logic            frame_tick = 1'b0;
  logic [N*11-1:0] x_flat;
  logic [N*11-1:0] y_flat;
  logic [N*4-1:0]  ctrl_flat;
  logic            busy;
  logic            done;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  string       tag_q[$];

  turtle_motion_ctrl #(.N(N), .H_MAX(640), .V_MAX(480)) dut (
    .clk(clk), .reset(reset), .cs(cs), .write(write), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .frame_tick(frame_tick),
    .x_flat(x_flat), .y_flat(y_flat), .ctrl_flat(ctrl_flat),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic observe(input logic [31:0] v);
    obs_q.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    tick();
    cs = 1'b0; write = 1'b0; wr_data = '0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rd_data;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask

  // Returns the number of busy cycles seen; stops on the done cycle.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      tick();
    end
  endtask

  function automatic logic [31:0] pos_w(input int y, input int x);
    return 32'((y << 11) | x);
  endfunction

  function automatic logic [31:0] mot_w(input int en, input int dy, input int dx, input int ctrl);
    return 32'((en << 12) | ((dy & 15) << 8) | ((dx & 15) << 4) | (ctrl & 15));
  endfunction

  function automatic logic [31:0] xo(input int i);
    return {21'b0, x_flat[11*i +: 11]};
  endfunction

  function automatic logic [31:0] yo(input int i);
    return {21'b0, y_flat[11*i +: 11]};
  endfunction

  task automatic test_reset();
    logic [31:0] d, e, o;
    string t;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    for (int a = 0; a < 64; a++) begin
      expect_val($sformatf("reset_rd_%02h", a), 32'h0);
      rd(6'(a), d);
      observe(d);
    end
    expect_val("reset_x_flat_zero", 32'd1); observe({31'b0, x_flat == '0});
    expect_val("reset_y_flat_zero", 32'd1); observe({31'b0, y_flat == '0});
    expect_val("reset_ctrl_zero", 32'd1);   observe({31'b0, ctrl_flat == '0});
    expect_val("reset_busy", 32'd0);        observe({31'b0, busy});
    expect_val("reset_done", 32'd0);        observe({31'b0, done});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front(); n_vec++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      if (o !== e) begin n_err++; $display("FAIL %s: got %h required %h", t, o, e); end
      else $display("ok   %s = %h", t, o);
    end
    obs_q.delete();
  endtask

  task automatic test_write_read();
    logic [31:0] d, e, o;
    string t;
    expect_val("pos3_x_flat", 32'd200);
    expect_val("pos3_y_flat", 32'd100);
    wr(6'h03, pos_w(100, 200));
    observe(xo(3));
    observe(yo(3));
    expect_val("pos3_rd", 32'h0003_20C8);
    rd(6'h03, d); observe(d);
    expect_val("mot3_rd", 32'h0000_12D5);
    expect_val("mot3_ctrl_flat", 32'd5);
    wr(6'h23, mot_w(1, 2, -3, 5));
    rd(6'h23, d); observe(d);
    observe({28'b0, ctrl_flat[15:12]});
    expect_val("pos_oob_rd", 32'h0);
    expect_val("mot_oob_rd", 32'h0);
    wr(6'h14, 32'h0012_3456);
    wr(6'h34, 32'h0000_1FFF);
    rd(6'h14, d); observe(d);
    rd(6'h34, d); observe(d);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front(); n_vec++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      if (o !== e) begin n_err++; $display("FAIL %s: got %h required %h", t, o, e); end
      else $display("ok   %s = %h", t, o);
    end
    obs_q.delete();
  endtask

  task automatic test_frame_update();
    logic [31:0] d, e, o;
    string t;
    int cyc;
    do_reset();
    wr(6'h00, pos_w(1, 638));    wr(6'h20, mot_w(1, -2, 3, 0));
    wr(6'h01, pos_w(0, 0));      wr(6'h21, mot_w(1, -1, -1, 0));
    wr(6'h02, pos_w(700, 2000)); wr(6'h22, mot_w(1, 0, 1, 0));
    wr(6'h07, pos_w(9, 5));      wr(6'h27, mot_w(0, 1, 1, 0));
    expect_val("frame_busy_cycles", 32'd20);
    expect_val("frame_done_pulse", 32'd1);
    expect_val("frame_done_cleared", 32'd0);
    expect_val("t0_x", 32'd1);    expect_val("t0_y", 32'd479);
    expect_val("t1_x", 32'd639);  expect_val("t1_y", 32'd479);
    expect_val("t2_x", 32'd1361); expect_val("t2_y", 32'd220);
    expect_val("t7_x", 32'd5);    expect_val("t7_y", 32'd9);
    expect_val("frame_csr", 32'h0000_0004);
    pulse_tick();
    wait_done(cyc);
    observe(32'(cyc));
    observe({31'b0, done});
    tick();
    observe({31'b0, done});
    observe(xo(0)); observe(yo(0));
    observe(xo(1)); observe(yo(1));
    observe(xo(2)); observe(yo(2));
    observe(xo(7)); observe(yo(7));
    rd(6'h3F, d); observe(d);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front(); n_vec++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      if (o !== e) begin n_err++; $display("FAIL %s: got %h required %h", t, o, e); end
      else $display("ok   %s = %h", t, o);
    end
    obs_q.delete();
  endtask

  task automatic test_collision_overrun();
    logic [31:0] d, e, o;
    string t;
    int cyc;
    do_reset();
    for (int i = 4; i <= 6; i++) begin
      wr(6'(i), pos_w(0, 10));
      wr(6'(32 + i), mot_w(1, 0, 1, 0));
    end
    expect_val("coll_done_pulse", 32'd1);
    expect_val("coll_csr_overrun", 32'h0000_0006);
    expect_val("coll_no_restart_0", 32'd0);
    expect_val("coll_no_restart_1", 32'd0);
    expect_val("coll_no_restart_2", 32'd0);
    expect_val("coll_t4_x", 32'd11);
    expect_val("coll_t5_x", 32'd300);
    expect_val("coll_t6_x", 32'd11);
    expect_val("coll_csr_cleared", 32'h0000_0004);
    pulse_tick();
    repeat (5) tick();
    wr(6'h05, pos_w(0, 300));    // lands on the edge that commits turtle 5
    repeat (3) tick();
    pulse_tick();                // tick at T+10, mid-update
    wait_done(cyc);
    observe({31'b0, done});
    tick();
    rd(6'h3F, d); observe(d);
    for (int k = 0; k < 3; k++) begin
      tick();
      observe({31'b0, busy});
    end
    observe(xo(4)); observe(xo(5)); observe(xo(6));
    wr(6'h3F, 32'h2);
    rd(6'h3F, d); observe(d);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front(); n_vec++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      if (o !== e) begin n_err++; $display("FAIL %s: got %h required %h", t, o, e); end
      else $display("ok   %s = %h", t, o);
    end
    obs_q.delete();
  endtask

  task automatic test_freeze();
    logic [31:0] d, e, o;
    string t;
    int cyc;
    expect_val("frz_busy_0", 32'd0);
    expect_val("frz_busy_1", 32'd0);
    expect_val("frz_busy_2", 32'd0);
    expect_val("frz_t4_x", 32'd11);
    expect_val("frz_csr", 32'h0000_0005);
    expect_val("unfrz_busy_cycles", 32'd20);
    expect_val("unfrz_t4_x", 32'd12);
    expect_val("unfrz_t5_x", 32'd301);
    expect_val("unfrz_t6_x", 32'd12);
    expect_val("unfrz_csr", 32'h0000_0008);
    wr(6'h3F, 32'h1);
    pulse_tick();
    for (int k = 0; k < 3; k++) begin
      observe({31'b0, busy});
      tick();
    end
    observe(xo(4));
    rd(6'h3F, d); observe(d);
    wr(6'h3F, 32'h0);
    pulse_tick();
    wait_done(cyc);
    observe(32'(cyc));
    tick();
    observe(xo(4)); observe(xo(5)); observe(xo(6));
    rd(6'h3F, d); observe(d);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front(); n_vec++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      if (o !== e) begin n_err++; $display("FAIL %s: got %h required %h", t, o, e); end
      else $display("ok   %s = %h", t, o);
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_update();
    logic [31:0] d, e, o;
    string t;
    expect_val("rst_mid_busy_pre", 32'd1);
    expect_val("rst_mid_busy", 32'd0);
    expect_val("rst_mid_x_zero", 32'd1);
    expect_val("rst_mid_csr", 32'h0);
    expect_val("rst_mid_no_done", 32'd0);
    pulse_tick();
    repeat (5) tick();
    observe({31'b0, busy});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    observe({31'b0, busy});
    observe({31'b0, x_flat == '0});
    rd(6'h3F, d); observe(d);
    begin
      logic any;
      any = 1'b0;
      for (int k = 0; k < 25; k++) begin
        any = any | done | busy;
        tick();
      end
      observe({31'b0, any});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front(); n_vec++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      if (o !== e) begin n_err++; $display("FAIL %s: got %h required %h", t, o, e); end
      else $display("ok   %s = %h", t, o);
    end
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, e, o;
    string t;
    int cyc;
    do_reset();
    wr(6'h13, pos_w(479, 639));
    wr(6'h33, mot_w(1, 7, 7, 3));
    expect_val("b2b_f1_cycles", 32'd20);
    expect_val("b2b_f1_x", 32'd6);
    expect_val("b2b_f1_y", 32'd6);
    expect_val("b2b_f2_cycles", 32'd20);
    expect_val("b2b_f2_x", 32'd13);
    expect_val("b2b_f2_y", 32'd13);
    expect_val("b2b_csr", 32'h0000_0008);
    expect_val("b2b_ctrl19", 32'd3);
    pulse_tick();
    wait_done(cyc); observe(32'(cyc));
    tick();
    observe(xo(19)); observe(yo(19));
    pulse_tick();
    wait_done(cyc); observe(32'(cyc));
    tick();
    observe(xo(19)); observe(yo(19));
    rd(6'h3F, d); observe(d);
    observe({28'b0, ctrl_flat[79:76]});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front(); n_vec++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      if (o !== e) begin n_err++; $display("FAIL %s: got %h required %h", t, o, e); end
      else $display("ok   %s = %h", t, o);
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_frame_update();
    test_collision_overrun();
    test_freeze();
    test_reset_mid_update();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
